// File: rtl/alu_pkg.sv
// Shared types, frame geometry and parity/framing helpers for the serial ALU controller.
package alu_pkg;

  localparam int FRAME_W   = 10;
  localparam int SEND_BITS = 3 * FRAME_W;

  typedef enum logic {
    DATA = 1'b0,
    CMD  = 1'b1
  } payload_type_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_RSP = 3'd2,
    RECV     = 3'd3,
    DONE     = 3'd4
  } ctrl_state_t;

  // Parity bit that makes the XOR of frame bits [9:1] equal to bit [0].
  function automatic logic frame_parity(input logic [FRAME_W-2:0] head);
    return ^head;
  endfunction

  function automatic logic [FRAME_W-1:0] build_frame(input payload_type_t ptype,
                                                     input logic [7:0]    data);
    logic [FRAME_W-2:0] head;
    head = {ptype, data};
    return {head, frame_parity(head)};
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bus between a client and the serial ALU controller.
interface alu_serial_ctrl_if;

  // Both channels: a transfer happens on a clock edge where valid and ready are
  // both 1; the source keeps valid and its payload stable until that edge.
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [7:0]  req_op;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_status;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_perr;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_data, rsp_perr, rsp_timeout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_data, rsp_perr, rsp_timeout
  );

endinterface

// File: rtl/alu_frame_deser.sv
// MSB-first 10-bit frame shift-in with bit counter and parity check; reused for each response frame.
module alu_frame_deser
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic       frame_done,
  output logic [7:0] frame_data,
  output logic       frame_perr
);

  logic [FRAME_W-2:0] shreg_q, shreg_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_full;

  // Completion is reported on the edge that shifts in the last bit, so the
  // caller can capture the frame in the same cycle.
  assign frame_full = {shreg_q, bit_in};
  assign frame_data = frame_full[8:1];
  assign frame_perr = frame_parity(frame_full[FRAME_W-1:1]) != frame_full[0];

  always_comb begin
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    frame_done = 1'b0;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = frame_full[FRAME_W-2:0];
      if (cnt_q == 4'(FRAME_W - 1)) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Sends {a, b, op} to a bit-serial ALU as three framed words and collects the
// three-frame response (status, MSB, LSB) with parity checking and a wait timeout.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_serial_ctrl_if.slave bus,
  output logic        din,
  output logic        enable_n,
  input  logic        dout,
  input  logic        dout_valid,
  output ctrl_state_t dbg_state
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  ctrl_state_t          state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic                 din_q, din_d;
  logic                 enable_n_q, enable_n_d;
  logic [SEND_BITS-1:0] tx_q, tx_d;
  logic [4:0]           snd_cnt_q, snd_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [1:0]           frm_idx_q, frm_idx_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [7:0]           rsp_status_q, rsp_status_d;
  logic [15:0]          rsp_data_q, rsp_data_d;
  logic [2:0]           rsp_perr_q, rsp_perr_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  logic [SEND_BITS-1:0] tx_word;
  logic                 deser_clear;
  logic                 deser_shift;
  logic                 deser_done;
  logic [7:0]           deser_data;
  logic                 deser_perr;

  assign tx_word = {build_frame(DATA, bus.req_a),
                    build_frame(DATA, bus.req_b),
                    build_frame(CMD,  bus.req_op)};

  alu_frame_deser u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (deser_clear),
    .shift_en   (deser_shift),
    .bit_in     (dout),
    .frame_done (deser_done),
    .frame_data (deser_data),
    .frame_perr (deser_perr)
  );

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    din_d         = din_q;
    enable_n_d    = enable_n_q;
    tx_d          = tx_q;
    snd_cnt_d     = snd_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    frm_idx_d     = frm_idx_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_status_d  = rsp_status_q;
    rsp_data_d    = rsp_data_q;
    rsp_perr_d    = rsp_perr_q;
    rsp_timeout_d = rsp_timeout_q;
    deser_clear   = 1'b0;
    deser_shift   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          // The first bit goes out on the accept edge; the rest of the word is
          // held so the request fields may change afterwards.
          din_d         = tx_word[SEND_BITS-1];
          tx_d          = {tx_word[SEND_BITS-2:0], 1'b0};
          enable_n_d    = 1'b0;
          snd_cnt_d     = 5'd1;
          req_ready_d   = 1'b0;
          rsp_status_d  = '0;
          rsp_data_d    = '0;
          rsp_perr_d    = '0;
          rsp_timeout_d = 1'b0;
          deser_clear   = 1'b1;
          state_d       = SEND;
        end
      end

      SEND: begin
        if (snd_cnt_q == 5'(SEND_BITS)) begin
          enable_n_d = 1'b1;
          din_d      = 1'b0;
          snd_cnt_d  = '0;
          tmo_cnt_d  = '0;
          state_d    = WAIT_RSP;
        end else begin
          din_d     = tx_q[SEND_BITS-1];
          tx_d      = {tx_q[SEND_BITS-2:0], 1'b0};
          snd_cnt_d = snd_cnt_q + 5'd1;
        end
      end

      WAIT_RSP: begin
        if (dout_valid) begin
          deser_shift = 1'b1;
          frm_idx_d   = '0;
          tmo_cnt_d   = '0;
          state_d     = RECV;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          tmo_cnt_d     = '0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_status_d  = '0;
          rsp_data_d    = '0;
          rsp_perr_d    = '0;
          state_d       = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      RECV: begin
        deser_shift = 1'b1;
        if (deser_done) begin
          frm_idx_d = frm_idx_q + 2'd1;
          if (frm_idx_q == 2'd0) begin
            rsp_status_d  = deser_data;
            rsp_perr_d[0] = deser_perr;
          end else if (frm_idx_q == 2'd1) begin
            rsp_data_d[15:8] = deser_data;
            rsp_perr_d[1]    = deser_perr;
          end else begin
            rsp_data_d[7:0] = deser_data;
            rsp_perr_d[2]   = deser_perr;
            frm_idx_d       = '0;
            rsp_valid_d     = 1'b1;
            state_d         = DONE;
          end
        end
      end

      DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        enable_n_d  = 1'b1;
        din_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      din_q         <= 1'b0;
      enable_n_q    <= 1'b1;
      tx_q          <= '0;
      snd_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      frm_idx_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= '0;
      rsp_data_q    <= '0;
      rsp_perr_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      din_q         <= din_d;
      enable_n_q    <= enable_n_d;
      tx_q          <= tx_d;
      snd_cnt_q     <= snd_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      frm_idx_q     <= frm_idx_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_data_q    <= rsp_data_d;
      rsp_perr_q    <= rsp_perr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign din             = din_q;
  assign enable_n        = enable_n_q;
  assign dbg_state       = state_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_perr    = rsp_perr_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
